// File: rtl/sdhcal_daq_pkg.sv
// Shared SDHCAL DAQ definitions: default word width, FIFO read-mode codes and a
// constant-foldable clog2 for sizing pointers and counters.
package sdhcal_daq_pkg;

    localparam int unsigned DAQ_WORD_W = 16;

    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    // Smallest n with 2**n >= value; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/scurve_fifo_ram.sv
// Simple dual-port storage for the S-curve FIFO: synchronous write, asynchronous read,
// so it maps onto distributed RAM and can feed the FWFT output path directly.
module scurve_fifo_ram
    import sdhcal_daq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DAQ_WORD_W,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned AW        = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/scurve_sync_fifo.sv
// Single-clock FIFO between the S-curve packer and the readout arbiter, with
// standard or first-word-fall-through read mode and registered level flags.
module scurve_sync_fifo
    import sdhcal_daq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DAQ_WORD_W,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned FWFT       = FIFO_STD,
    parameter int unsigned AF_LEVEL   = 14,
    parameter int unsigned AE_LEVEL   = 2,
    localparam int unsigned AW        = clog2(DEPTH),
    localparam int unsigned CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         data_count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, empty_q, af_q, ae_q;
    logic                  ovf_q, unf_q;
    logic                  rd_accept, wr_accept;
    logic [DATA_WIDTH-1:0] rdata;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    always_comb begin
        rd_accept = rd_en & ~empty_q;
        wr_accept = wr_en & (~full_q | rd_accept);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_accept && !rd_accept) begin
            count_d = count_q + CW'(1);
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
            af_q     <= (count_d >= CW'(AF_LEVEL));
            ae_q     <= (count_d <= CW'(AE_LEVEL));
            ovf_q    <= wr_en & ~wr_accept;
            unf_q    <= rd_en & ~rd_accept;
        end
    end

    scurve_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Head word is shown while non-empty; masked to zero so reset dout is clean.
            assign dout  = empty_q ? '0 : rdata;
            assign valid = ~empty_q;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_accept;
                    if (rd_accept) begin
                        dout_q <= rdata;
                    end
                end
            end

            assign dout  = dout_q;
            assign valid = valid_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign data_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_scurve_sync_fifo.sv
// Bench for scurve_sync_fifo: standard and FWFT instances share stimulus and are
// compared each cycle against a queue-based model of the FIFO.
`timescale 1ns/1ps
module tb_scurve_sync_fifo;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 14;
    localparam int unsigned AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_valid, f_valid, s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
    logic [4:0]    s_cnt, f_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_sdout = '0;
    logic          exp_svalid = 1'b0;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    always #12.5 clk = ~clk;

    scurve_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(s_dout), .valid(s_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .data_count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf)
    );

    scurve_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .data_count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("s_count", 32'(s_cnt), 32'(n));
        check("f_count", 32'(f_cnt), 32'(n));
        check("s_full", 32'(s_full), 32'(n == DEPTH));
        check("f_full", 32'(f_full), 32'(n == DEPTH));
        check("s_empty", 32'(s_empty), 32'(n == 0));
        check("f_empty", 32'(f_empty), 32'(n == 0));
        check("s_afull", 32'(s_af), 32'(n >= AF));
        check("f_afull", 32'(f_af), 32'(n >= AF));
        check("s_aempty", 32'(s_ae), 32'(n <= AE));
        check("f_aempty", 32'(f_ae), 32'(n <= AE));
        check("s_ovf", 32'(s_ovf), 32'(exp_ovf));
        check("f_ovf", 32'(f_ovf), 32'(exp_ovf));
        check("s_unf", 32'(s_unf), 32'(exp_unf));
        check("f_unf", 32'(f_unf), 32'(exp_unf));
        check("s_valid", 32'(s_valid), 32'(exp_svalid));
        check("s_dout", 32'(s_dout), 32'(exp_sdout));
        check("f_valid", 32'(f_valid), 32'(n > 0));
        check("f_dout", 32'(f_dout), (n > 0) ? 32'(q[0]) : 32'd0);
    endtask

    task automatic model_reset();
        q.delete();
        exp_sdout  = '0;
        exp_svalid = 1'b0;
        exp_ovf    = 1'b0;
        exp_unf    = 1'b0;
    endtask

    // One clock: apply inputs, advance the model at the edge, check just after it.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        logic racc, wacc;
        @(negedge clk);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        racc = r && (q.size() > 0);
        wacc = w && ((q.size() < DEPTH) || racc);
        exp_svalid = racc;
        if (racc) exp_sdout = q.pop_front();
        if (wacc) q.push_back(d);
        exp_ovf = w && !wacc;
        exp_unf = r && !racc;
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #100 rst = 1'b0;
        #1 check_all();

        // Fill with 0x0..0xF, one write every other cycle, then overflow.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'(i), 1'b0);
            step(1'b0, '0, 1'b0);
        end
        step(1'b1, 16'h0055, 1'b0);
        step(1'b0, '0, 1'b0);

        // Drain in order, then one underflowing read.
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Single write into empty, visible on FWFT output, then popped.
        step(1'b1, 16'h0005, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);

        // Simultaneous read and write when full and when empty.
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b1, 16'h000A, 1'b1);
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 16'h000F, 1'b1);
        step(1'b0, '0, 1'b1);

        // Asynchronous reset with seven words stored.
        for (int i = 0; i < 7; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #3 rst = 1'b1;
        model_reset();
        #1 check_all();
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 16'h0003, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Randomised traffic in write-heavy, read-heavy and balanced phases.
        for (int i = 0; i < 3000; i++) begin
            int unsigned pw;
            case ((i / 300) % 3)
                0:       pw = 75;
                1:       pw = 25;
                default: pw = 50;
            endcase
            step($urandom_range(99, 0) < pw, 16'($urandom), $urandom_range(99, 0) < (100 - pw));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
